// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC core sequencer: state encodings,
// opcode constants and the opcode classifier used by the decode step.
package cpu_pkg;

    // Sequencer states; the encodings are visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Coarse instruction class derived from the opcode field.
    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_ALU = 3'd1,
        CLS_LD  = 3'd2,
        CLS_ST  = 3'd3,
        CLS_HLT = 3'd4
    } opc_class_t;

    localparam int unsigned OPC_NOP    = 32'h0;
    localparam int unsigned OPC_ALU_LO = 32'h1;
    localparam int unsigned OPC_ALU_HI = 32'h7;
    localparam int unsigned OPC_LD     = 32'h8;
    localparam int unsigned OPC_ST     = 32'h9;
    localparam int unsigned OPC_HLT    = 32'hF;

    // Unassigned opcodes (0xA-0xE and anything wider) fall through to NOP.
    function automatic opc_class_t opc_classify(input int unsigned opc);
        opc_class_t cls;
        cls = CLS_NOP;
        if (opc >= OPC_ALU_LO && opc <= OPC_ALU_HI) begin
            cls = CLS_ALU;
        end else if (opc == OPC_LD) begin
            cls = CLS_LD;
        end else if (opc == OPC_ST) begin
            cls = CLS_ST;
        end else if (opc == OPC_HLT) begin
            cls = CLS_HLT;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Memory-acknowledge wait counter. Counts cycles spent waiting for mem_ack
// and flags when the count has reached ACK_TIMEOUT.
module ack_timer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Clear has priority; counting stops once the limit is reached so the
    // counter never wraps while the sequencer leaves for ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !timeout) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout = (cnt_q == CNT_W'(ACK_TIMEOUT));

endmodule

// File: rtl/mem_seq_ctrl.sv
// Instruction sequencer for the 8-bit RISC core: fetch/decode/execute/memory
// phases with a req/ack memory handshake, address-source select MA and the
// IR-load, PC-increment, ALU-enable and register-write strobes.
module mem_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int OPC_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ack,
    output logic             MA,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             alu_en,
    output logic             reg_we,
    output logic             halted,
    output logic             bus_err,
    output logic [2:0]       state
);

    state_t     state_q;
    state_t     state_d;
    state_t     next_fetch;
    opc_class_t dec_cls;
    logic       is_st_q;
    logic       tmr_active;
    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_timeout;

    assign dec_cls    = opc_classify(32'(opcode));
    // Instruction boundary: run is only looked at here and in IDLE.
    assign next_fetch = run ? ST_FETCH : ST_IDLE;

    // The timer only runs while a bus access is outstanding. Every exit from
    // FETCH/MEM happens either on an ack or into a non-access state, so
    // clearing on ack or inactivity guarantees a zero count on entry.
    assign tmr_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign tmr_clr    = !tmr_active || mem_ack;
    assign tmr_en     = tmr_active && !mem_ack;

    ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .timeout (tmr_timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture LD/ST direction in DECODE so opcode may change during MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_st_q <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            is_st_q <= (dec_cls == CLS_ST);
        end
    end

    // Next-state and strobe decode; FETCH/MEM strobes are Mealy on mem_ack.
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        alu_en  = 1'b0;
        reg_we  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmr_timeout) begin
                    state_d = ST_ERR;
                end
            end

            ST_DECODE: begin
                unique case (dec_cls)
                    CLS_ALU: state_d = ST_EXEC;
                    CLS_LD:  state_d = ST_MEM;
                    CLS_ST:  state_d = ST_MEM;
                    CLS_HLT: state_d = ST_HALT;
                    default: state_d = next_fetch;
                endcase
            end

            ST_EXEC: begin
                alu_en  = 1'b1;
                reg_we  = 1'b1;
                state_d = next_fetch;
            end

            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_st_q;
                if (mem_ack) begin
                    reg_we  = !is_st_q;
                    state_d = next_fetch;
                end else if (tmr_timeout) begin
                    state_d = ST_ERR;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign MA      = (state_q != ST_MEM);
    assign halted  = (state_q == ST_HALT);
    assign bus_err = (state_q == ST_ERR);
    assign state   = state_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl. Each instruction is expanded into a
// per-cycle script (inputs plus expected outputs) from its opcode, the
// number of memory wait cycles and whether run stays high at its end.
module tb_mem_seq_ctrl;

    localparam int TO = 15;

    // Flag vector layout: {MA, req, we, ir_load, pc_inc, alu_en, reg_we, halted, bus_err}
    localparam logic [8:0] F_IDLE   = 9'b100000000;
    localparam logic [8:0] F_FWAIT  = 9'b110000000;
    localparam logic [8:0] F_FACK   = 9'b110110000;
    localparam logic [8:0] F_DEC    = 9'b100000000;
    localparam logic [8:0] F_EXEC   = 9'b100001100;
    localparam logic [8:0] F_HALT   = 9'b100000010;
    localparam logic [8:0] F_ERR    = 9'b100000001;
    localparam logic [8:0] F_RST    = 9'b100000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       mem_ack = 1'b0;
    logic       MA, mem_req, mem_we, ir_load, pc_inc, alu_en, reg_we, halted, bus_err;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic [8:0] f;
    } exp_t;

    typedef struct {
        bit         ack;
        bit         run_v;
        logic [3:0] opc;
        exp_t       e;
    } cyc_t;

    cyc_t plan[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_seq_ctrl #(.ACK_TIMEOUT(TO), .OPC_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .opcode  (opcode),
        .mem_ack (mem_ack),
        .MA      (MA),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .ir_load (ir_load),
        .pc_inc  (pc_inc),
        .alu_en  (alu_en),
        .reg_we  (reg_we),
        .halted  (halted),
        .bus_err (bus_err),
        .state   (state)
    );

    always #5 clk = ~clk;

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] ropc();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic exp_t ex(input logic [2:0] st, input logic [8:0] f);
        exp_t e;
        e.st = st;
        e.f  = f;
        return e;
    endfunction

    function automatic void push(input bit ack, input bit run_v, input logic [3:0] opc,
                                 input exp_t e);
        cyc_t c;
        c.ack = ack;
        c.run_v = run_v;
        c.opc = opc;
        c.e = e;
        plan.push_back(c);
    endfunction

    // Leave IDLE: one IDLE cycle with run high.
    function automatic void plan_start();
        push(rbit(), 1'b1, ropc(), ex(3'd0, F_IDLE));
    endfunction

    // Memory-phase flags for LD/ST, wait or ack cycle.
    function automatic logic [8:0] f_mem(input bit is_st, input bit ack);
        logic [8:0] f;
        f = 9'b010000000;
        if (is_st) f = f | 9'b001000000;
        if (!is_st && ack) f = f | 9'b000000100;
        return f;
    endfunction

    // One instruction: wf fetch waits, wm memory waits, run level at the
    // instruction boundary, then idle cycles before run returns if it dropped.
    function automatic void plan_instr(input logic [3:0] opc, input int wf, input int wm,
                                       input bit end_run, input int idle_n);
        bit is_alu, is_mem, is_hlt;
        is_alu = (opc >= 4'h1 && opc <= 4'h7);
        is_mem = (opc == 4'h8 || opc == 4'h9);
        is_hlt = (opc == 4'hF);
        for (int i = 0; i < wf; i++) push(1'b0, rbit(), ropc(), ex(3'd1, F_FWAIT));
        push(1'b1, rbit(), ropc(), ex(3'd1, F_FACK));
        push(rbit(), (is_alu || is_mem || is_hlt) ? rbit() : end_run, opc, ex(3'd2, F_DEC));
        if (is_hlt) return;
        if (is_alu) push(rbit(), end_run, ropc(), ex(3'd3, F_EXEC));
        if (is_mem) begin
            for (int i = 0; i < wm; i++)
                push(1'b0, end_run ? rbit() : 1'b0, ropc(), ex(3'd4, f_mem(opc == 4'h9, 1'b0)));
            push(1'b1, end_run, ropc(), ex(3'd4, f_mem(opc == 4'h9, 1'b1)));
        end
        if (!end_run) begin
            for (int i = 0; i < idle_n; i++) push(rbit(), 1'b0, ropc(), ex(3'd0, F_IDLE));
            plan_start();
        end
    endfunction

    // Apply one cycle of inputs just after the rising edge, sample at the falling edge.
    task automatic drive_cycle(input cyc_t c, output exp_t obs);
        @(posedge clk);
        #1;
        mem_ack = c.ack;
        run     = c.run_v;
        opcode  = c.opc;
        @(negedge clk);
        obs = {state, MA, mem_req, mem_we, ir_load, pc_inc, alu_en, reg_we, halted, bus_err};
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        run     = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t obs;
        rst_n = 1'b0;
        run = 1'b1;
        mem_ack = 1'b1;
        opcode = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {state, MA, mem_req, mem_we, ir_load, pc_inc, alu_en, reg_we, halted, bus_err};
            n_checks++;
            if (obs !== ex(3'd0, F_RST)) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, ex(3'd0, F_RST));
            end
        end
        do_reset();
    endtask

    task automatic test_alu_stream();
        cyc_t c;
        exp_t obs;
        int   k = 0;
        do_reset();
        plan_start();
        for (int i = 0; i < 4; i++) plan_instr(4'h3, 0, 0, 1'b1, 0);
        while (plan.size() > 0) begin
            c = plan.pop_front();
            drive_cycle(c, obs);
            n_checks++;
            if (obs !== c.e) begin
                n_fail++;
                $display("FAIL alu_stream cyc %0d: got %b want %b", k, obs, c.e);
            end
            k++;
        end
    endtask

    task automatic test_ld_st();
        cyc_t c;
        exp_t obs;
        int   k = 0;
        do_reset();
        plan_start();
        plan_instr(4'h8, 0, 2, 1'b1, 0);
        plan_instr(4'h9, 0, 0, 1'b1, 0);
        plan_instr(4'h9, 1, 3, 1'b1, 0);
        plan_instr(4'h0, 0, 0, 1'b1, 0);
        plan_instr(4'hB, 2, 0, 1'b1, 0);
        while (plan.size() > 0) begin
            c = plan.pop_front();
            drive_cycle(c, obs);
            n_checks++;
            if (obs !== c.e) begin
                n_fail++;
                $display("FAIL ld_st cyc %0d: got %b want %b", k, obs, c.e);
            end
            k++;
        end
    endtask

    task automatic test_timeout();
        cyc_t c;
        exp_t obs;
        int   k = 0;
        // Fetch never acknowledged: 16 waiting FETCH cycles, then sticky ERR.
        do_reset();
        plan_start();
        for (int i = 0; i < TO + 1; i++) push(1'b0, rbit(), ropc(), ex(3'd1, F_FWAIT));
        for (int i = 0; i < 6; i++) push(rbit(), rbit(), ropc(), ex(3'd6, F_ERR));
        while (plan.size() > 0) begin
            c = plan.pop_front();
            drive_cycle(c, obs);
            n_checks++;
            if (obs !== c.e) begin
                n_fail++;
                $display("FAIL timeout_fetch cyc %0d: got %b want %b", k, obs, c.e);
            end
            k++;
        end
        // Ack exactly at the limit completes normally, in FETCH and in MEM.
        do_reset();
        plan_start();
        plan_instr(4'h0, TO, 0, 1'b1, 0);
        plan_instr(4'h8, 0, TO, 1'b1, 0);
        plan_instr(4'h3, 0, 0, 1'b1, 0);
        // Memory phase never acknowledged.
        plan_instr(4'h0, 0, 0, 1'b1, 0);
        push(1'b1, 1'b1, ropc(), ex(3'd1, F_FACK));
        push(1'b0, 1'b1, 4'h9, ex(3'd2, F_DEC));
        for (int i = 0; i < TO + 1; i++) push(1'b0, rbit(), ropc(), ex(3'd4, f_mem(1'b1, 1'b0)));
        for (int i = 0; i < 4; i++) push(rbit(), rbit(), ropc(), ex(3'd6, F_ERR));
        k = 0;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            drive_cycle(c, obs);
            n_checks++;
            if (obs !== c.e) begin
                n_fail++;
                $display("FAIL timeout_edge cyc %0d: got %b want %b", k, obs, c.e);
            end
            k++;
        end
    endtask

    task automatic test_halt();
        cyc_t c;
        exp_t obs;
        int   k = 0;
        do_reset();
        plan_start();
        plan_instr(4'h5, 0, 0, 1'b1, 0);
        plan_instr(4'hF, 1, 0, 1'b1, 0);
        for (int i = 0; i < 6; i++) push(rbit(), rbit(), ropc(), ex(3'd5, F_HALT));
        while (plan.size() > 0) begin
            c = plan.pop_front();
            drive_cycle(c, obs);
            n_checks++;
            if (obs !== c.e) begin
                n_fail++;
                $display("FAIL halt cyc %0d: got %b want %b", k, obs, c.e);
            end
            k++;
        end
        // Asynchronous reset mid-cycle leaves HALT immediately.
        #2;
        rst_n = 1'b0;
        #1;
        obs = {state, MA, mem_req, mem_we, ir_load, pc_inc, alu_en, reg_we, halted, bus_err};
        n_checks++;
        if (obs !== ex(3'd0, F_RST)) begin
            n_fail++;
            $display("FAIL halt_async_rst: got %b want %b", obs, ex(3'd0, F_RST));
        end
    endtask

    task automatic test_run_drop();
        cyc_t c;
        exp_t obs;
        int   k = 0;
        do_reset();
        plan_start();
        plan_instr(4'h8, 1, 3, 1'b0, 3);
        plan_instr(4'h2, 0, 0, 1'b0, 2);
        plan_instr(4'h9, 0, 1, 1'b1, 0);
        for (int i = 0; i < 2; i++) push(1'b0, 1'b1, ropc(), ex(3'd1, F_FWAIT));
        while (plan.size() > 0) begin
            c = plan.pop_front();
            drive_cycle(c, obs);
            n_checks++;
            if (obs !== c.e) begin
                n_fail++;
                $display("FAIL run_drop cyc %0d: got %b want %b", k, obs, c.e);
            end
            k++;
        end
        // Mid-FETCH reset with ack present: request drops at once, no IR load.
        #1;
        mem_ack = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        obs = {state, MA, mem_req, mem_we, ir_load, pc_inc, alu_en, reg_we, halted, bus_err};
        n_checks++;
        if (obs !== ex(3'd0, F_RST)) begin
            n_fail++;
            $display("FAIL fetch_async_rst: got %b want %b", obs, ex(3'd0, F_RST));
        end
    endtask

    task automatic test_random();
        cyc_t       c;
        exp_t       obs;
        int         k = 0;
        logic [3:0] opc;
        int         wf;
        do_reset();
        plan_start();
        for (int i = 0; i < 60; i++) begin
            opc = 4'($urandom_range(0, 14));
            wf  = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3));
            plan_instr(opc, wf, int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 2)));
        end
        plan_instr(4'hF, 0, 0, 1'b1, 0);
        for (int i = 0; i < 3; i++) push(rbit(), rbit(), ropc(), ex(3'd5, F_HALT));
        while (plan.size() > 0) begin
            c = plan.pop_front();
            drive_cycle(c, obs);
            n_checks++;
            if (obs !== c.e) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", k, obs, c.e);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_ld_st();
        test_timeout();
        test_halt();
        test_run_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
- Instruction-sequencing controller for the 8-bit RISC core.
- Drives the memory address source select `MA`:
  - `MA`=1 routes PC to the memory address bus.
  - `MA`=0 routes register address `a_data` to the memory address bus.
- Runs fetch/decode/execute/memory phases with a req/ack memory handshake.
- Issues the IR-load, PC-increment, ALU-enable and register-write strobes.
- Sits between the IR opcode field, the memory interface and the datapath.

Parameters:
- `ACK_TIMEOUT`, 15: maximum wait cycles for `mem_ack` before a bus error (1..255).
- `OPC_W`, 4: opcode field width.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `run`  input  1  level; enables instruction execution.
- `opcode`  input  `OPC_W`  opcode field from IR; valid from the cycle after `ir_load`.
- `mem_ack`  input  1  memory completion; sampled only while `mem_req`=1.
- `MA`  output  1  address mux select (1 = PC, 0 = `a_data`).
- `mem_req`  output  1  memory access request.
- `mem_we`  output  1  write enable; valid with `mem_req`.
- `ir_load`  output  1  one-cycle IR load strobe.
- `pc_inc`  output  1  one-cycle PC increment strobe.
- `alu_en`  output  1  ALU result enable.
- `reg_we`  output  1  register-file write strobe.
- `halted`  output  1  HLT executed (sticky).
- `bus_err`  output  1  ack timeout (sticky).
- `state`  output  3  current state, for debug.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5, ERR=6.
- Reset (async, `rst_n`=0):
  - `state`=IDLE, `MA`=1, wait counter=0.
  - All other outputs 0.
  - Reset mid-access drops `mem_req` immediately.
- `MA` by state: 0 only in MEM, 1 in every other state. It is combinational from `state`.
- IDLE: `run`=1 -> FETCH; otherwise stay.
- FETCH:
  - Outputs: `mem_req`=1, `mem_we`=0.
  - In the cycle `mem_ack`=1: `ir_load`=1 and `pc_inc`=1 (Mealy), then -> DECODE.
- DECODE, one cycle, no strobes. Next state by `opcode`:
  - 0x0 NOP -> next-fetch.
  - 0x1-0x7 ALU ops -> EXEC.
  - 0x8 LD -> MEM.
  - 0x9 ST -> MEM.
  - 0xF HLT -> HALT.
  - 0xA-0xE -> treated as NOP.
- EXEC: `alu_en`=1 and `reg_we`=1 for exactly one cycle -> next-fetch.
- MEM:
  - Outputs: `mem_req`=1; `mem_we`=1 for ST, 0 for LD.
  - The opcode class is latched in DECODE; `opcode` changing during MEM has no effect.
  - On `mem_ack`: LD asserts `reg_we`=1 that cycle; ST does not. Then -> next-fetch.
- next-fetch: go to FETCH if `run`=1, else IDLE. `run` is therefore honoured only at instruction boundaries.
- HALT: `halted`=1; exit only via reset. `run` is ignored.
- ERR: `bus_err`=1 and all strobes 0; exit only via reset.
- Wait counter (width ceil(log2(`ACK_TIMEOUT`+1))):
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM with `mem_ack`=0.
  - If count == `ACK_TIMEOUT` and `mem_ack`=0 -> ERR.
  - `mem_ack` in the same cycle as the timeout wins: normal completion.
- `mem_ack` outside FETCH/MEM is ignored; it produces no strobes and no state change.
- Strobes `ir_load`, `pc_inc`, `reg_we`, `alu_en` are never high for more than one consecutive cycle per instruction.
- Latency with zero-wait memory (ack same cycle as req):
  - NOP: 2 cycles.
  - ALU: 3 cycles.
  - LD/ST: 3 cycles.
  - Each memory wait cycle adds 1.

Decomposition:
- Shared package `cpu_pkg` holds:
  - the state enum/encodings;
  - the opcode constants (`OPC_NOP`, `OPC_LD`=0x8, `OPC_ST`=0x9, `OPC_HLT`=0xF, ALU range bounds).
- One natural sub-module: `ack_timer`, the wait counter with clear/enable/timeout output, parameterised by `ACK_TIMEOUT`.
- FSM and output decode stay in `mem_seq_ctrl`.

Test Plan:
1. Reset then `run`=1, ack tied 1, opcode=0x3 -> states 1,2,3,1 repeating; `ir_load`/`pc_inc` high in FETCH cycles; `alu_en`=`reg_we`=1 in EXEC; `MA`=1 throughout.
2. opcode=0x8 (LD), ack delayed 2 cycles in MEM -> `MA`=0 for 3 cycles, `mem_we`=0, `reg_we`=1 only in the ack cycle, then FETCH with `MA`=1.
3. opcode=0x9 (ST), ack immediate -> one MEM cycle with `mem_req`=1, `mem_we`=1, `MA`=0, `reg_we`=0.
4. Timeout:
   - `ACK_TIMEOUT`=15, ack never asserted in FETCH -> enters ERR after cycle 16 in FETCH, `bus_err`=1 sticky, `run` toggling ignored.
   - Repeat with ack arriving exactly at count 15 -> normal DECODE, no error.
5. opcode=0xF -> `halted`=1 after DECODE; further ack and `run` ignored; `rst_n` pulse low async -> IDLE, `halted`=0, `MA`=1.
6. `run` dropped during MEM wait -> access completes, FSM goes to IDLE not FETCH. Separately, `rst_n` asserted mid-FETCH -> `mem_req`=0 immediately, no `ir_load`.
